// File: rtl/cbd_pkg.sv
// rtl/cbd_pkg.sv - shared types and constants for the CBD sampler controller
package cbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT,
    ST_DONE
  } cbd_state_e;

  localparam int ETA2 = 2;
  localparam int ETA3 = 3;
  localparam int CBD_N_COEF_DEF = 256;

  typedef logic signed [2:0] coef_t;

  // Bit-counter value at which the final bit of a coefficient is accepted.
  function automatic logic [2:0] last_bit_cnt(input logic eta3);
    return eta3 ? 3'(2 * ETA3 - 1) : 3'(2 * ETA2 - 1);
  endfunction

endpackage

// File: rtl/cbd_popdiff.sv
// rtl/cbd_popdiff.sv - popcount(a) - popcount(b) over collected bits for eta 2 or 3
module cbd_popdiff
  import cbd_pkg::*;
(
  input  logic       eta3,
  input  logic [5:0] bits,
  output coef_t      coef
);

  logic [1:0] pop_a;
  logic [1:0] pop_b;

  // Layout is a in the low eta bits, b in the next eta bits.
  always_comb begin
    if (eta3) begin
      pop_a = 2'(bits[0]) + 2'(bits[1]) + 2'(bits[2]);
      pop_b = 2'(bits[3]) + 2'(bits[4]) + 2'(bits[5]);
    end else begin
      pop_a = 2'(bits[0]) + 2'(bits[1]);
      pop_b = 2'(bits[2]) + 2'(bits[3]);
    end
    coef = coef_t'({1'b0, pop_a} - {1'b0, pop_b});
  end

endmodule

// File: rtl/cbd_ctrl.sv
// rtl/cbd_ctrl.sv - serial-bit centered binomial coefficient sampler controller
module cbd_ctrl
  import cbd_pkg::*;
#(
  parameter int N_COEF = CBD_N_COEF_DEF,
  parameter int IDX_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             eta_sel,
  input  logic             rnd,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic [2:0]       coef,
  output logic [IDX_W-1:0] coef_idx,
  output logic             coef_valid,
  input  logic             coef_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COEF - 1);

  cbd_state_e       state_q, state_d;
  logic             eta3_q, eta3_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [5:0]       bits_q, bits_d;
  coef_t            coef_q, coef_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rnd_ready_q, rnd_ready_d;
  logic             coef_valid_q, coef_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [5:0]       bits_acc;
  coef_t            coef_calc;

  // Fed with the bits including the one being accepted, so coef lands with the EMIT entry.
  cbd_popdiff u_popdiff (
    .eta3 (eta3_q),
    .bits (bits_acc),
    .coef (coef_calc)
  );

  always_comb begin
    state_d  = state_q;
    eta3_d   = eta3_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    coef_d   = coef_q;
    idx_d    = idx_q;
    bits_acc = bits_q | (6'(rnd) << cnt_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          eta3_d  = eta_sel;
          cnt_d   = 3'd0;
          bits_d  = 6'd0;
          idx_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (rnd_valid && rnd_ready_q) begin
          bits_d = bits_acc;
          if (cnt_q == last_bit_cnt(eta3_q)) begin
            coef_d  = coef_calc;
            state_d = ST_EMIT;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_EMIT: begin
        if (coef_valid_q && coef_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = 3'd0;
            bits_d  = 6'd0;
            state_d = ST_COLLECT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rnd_ready_d  = (state_d == ST_COLLECT);
    coef_valid_d = (state_d == ST_EMIT);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      eta3_q       <= 1'b0;
      cnt_q        <= 3'd0;
      bits_q       <= 6'd0;
      coef_q       <= '0;
      idx_q        <= '0;
      rnd_ready_q  <= 1'b0;
      coef_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      eta3_q       <= eta3_d;
      cnt_q        <= cnt_d;
      bits_q       <= bits_d;
      coef_q       <= coef_d;
      idx_q        <= idx_d;
      rnd_ready_q  <= rnd_ready_d;
      coef_valid_q <= coef_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rnd_ready  = rnd_ready_q;
  assign coef       = coef_q;
  assign coef_idx   = idx_q;
  assign coef_valid = coef_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
